// File: rtl/tile_dispatch_scheduler.sv
// tile_dispatch_scheduler
//   Walks an IMG_ROWS x IMG_COLS image in BLOCK_SIZE x BLOCK_SIZE tiles in raster
//   order and hands each tile to the lowest-numbered idle lane of a shared
//   compress-lane array. It tracks in-flight tiles, counts completions, and
//   reports either image completion or the end of an abort drain.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start_img       begin an image (honoured only while idle)
//   abort           stop dispatching (honoured only while running)
//   lane_done       per-lane completion pulse
//   lane_start      one-hot pulse: lane takes the tile on lane_tile_row/col
//   lane_tile_row   tile row index, valid with |lane_start
//   lane_tile_col   tile column index, valid with |lane_start
//   lane_sel        binary index of the started lane, valid with |lane_start
//   busy            scheduler is not idle
//   img_done        pulse: all tiles of the image completed
//   aborted         pulse: drain after an abort finished
//   tiles_done      completions accepted during the current image
//   err_spurious    sticky: lane_done seen on a lane with no tile in flight
module tile_dispatch_scheduler #(
  parameter int IMG_ROWS   = 480,
  parameter int IMG_COLS   = 640,
  parameter int BLOCK_SIZE = 8,
  parameter int NUM_LANES  = 4,
  localparam int NTR = IMG_ROWS / BLOCK_SIZE,
  localparam int NTC = IMG_COLS / BLOCK_SIZE,
  localparam int NT  = NTR * NTC,
  localparam int RW  = (NTR > 1) ? $clog2(NTR) : 1,
  localparam int CW  = (NTC > 1) ? $clog2(NTC) : 1,
  localparam int TW  = $clog2(NT + 1),
  localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_img,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic [NUM_LANES-1:0] lane_start,
  output logic [RW-1:0]        lane_tile_row,
  output logic [CW-1:0]        lane_tile_col,
  output logic [LW-1:0]        lane_sel,
  output logic                 busy,
  output logic                 img_done,
  output logic                 aborted,
  output logic [TW-1:0]        tiles_done,
  output logic                 err_spurious
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               state_reg, state_next;
  logic [RW-1:0]        row_reg;
  logic [CW-1:0]        col_reg;
  logic [NUM_LANES-1:0] lane_busy_reg;
  logic [TW-1:0]        tiles_done_reg;
  logic                 err_reg;
  logic                 img_done_reg;
  logic                 aborted_reg;

  logic                 free_found;
  logic [LW-1:0]        free_idx;
  logic                 last_tile;
  logic                 dispatch;
  logic                 drain_exit;
  logic [NUM_LANES-1:0] accepted;
  logic [TW-1:0]        accepted_cnt;

  // Lowest-index lane that was idle at the last clock edge. A lane freed by
  // lane_done in this cycle is deliberately not visible here until next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!lane_busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = LW'(i);
      end
    end
  end

  assign last_tile  = (row_reg == RW'(NTR - 1)) && (col_reg == CW'(NTC - 1));
  // Abort takes priority over any dispatch, including the final one.
  assign dispatch   = (state_reg == S_RUN) && !abort && free_found;
  // Completions only count while an image is active; in IDLE every pulse is spurious.
  assign accepted   = (state_reg != S_IDLE) ? (lane_done & lane_busy_reg) : '0;
  // Leave DRAIN only once nothing is in flight and no completion is arriving.
  assign drain_exit = (state_reg == S_DRAIN) && (lane_busy_reg == '0) && (lane_done == '0);

  always_comb begin
    accepted_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      accepted_cnt = accepted_cnt + TW'(accepted[i]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_img) state_next = S_RUN;
      S_RUN:   if (abort || (dispatch && last_tile)) state_next = S_DRAIN;
      S_DRAIN: if (drain_exit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    lane_start    = '0;
    lane_sel      = '0;
    lane_tile_row = '0;
    lane_tile_col = '0;
    busy          = (state_reg != S_IDLE);
    if (dispatch) begin
      lane_start    = NUM_LANES'(1) << free_idx;
      lane_sel      = free_idx;
      lane_tile_row = row_reg;
      lane_tile_col = col_reg;
    end
  end

  assign tiles_done   = tiles_done_reg;
  assign err_spurious = err_reg;
  assign img_done     = img_done_reg;
  assign aborted      = aborted_reg;

  // Datapath: tile cursor, in-flight mask, completion count and status pulses.
  // The done/aborted pulses are registered so they coincide with the first
  // IDLE cycle, i.e. with busy falling.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg        <= '0;
      col_reg        <= '0;
      lane_busy_reg  <= '0;
      tiles_done_reg <= '0;
      err_reg        <= 1'b0;
      img_done_reg   <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      img_done_reg <= drain_exit && (tiles_done_reg == TW'(NT));
      aborted_reg  <= drain_exit && (tiles_done_reg != TW'(NT));
      if ((lane_done & ~accepted) != '0) begin
        err_reg <= 1'b1;
      end
      if ((state_reg == S_IDLE) && start_img) begin
        row_reg        <= '0;
        col_reg        <= '0;
        lane_busy_reg  <= '0;
        tiles_done_reg <= '0;
      end else begin
        lane_busy_reg  <= (lane_busy_reg & ~accepted) | lane_start;
        tiles_done_reg <= tiles_done_reg + accepted_cnt;
        // The cursor parks on the last tile instead of wrapping.
        if (dispatch && !last_tile) begin
          if (col_reg == CW'(NTC - 1)) begin
            col_reg <= '0;
            row_reg <= row_reg + RW'(1);
          end else begin
            col_reg <= col_reg + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_dispatch_scheduler.sv
// Testbench for tile_dispatch_scheduler: 32x32 image, 8x8 tiles (4x4 tiles), 4 lanes.
// Part 1 applies a table of hand-derived vectors, part 2 runs randomized lane
// traffic against a transaction-level model, part 3 hits abort on the final tile.
module tb_tile_dispatch_scheduler;

  localparam int NL  = 4;
  localparam int NTC = 4;
  localparam int NTR = 4;
  localparam int NT  = NTR * NTC;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_img;
  logic          abort;
  logic [NL-1:0] lane_done;
  logic [NL-1:0] lane_start;
  logic [1:0]    lane_tile_row;
  logic [1:0]    lane_tile_col;
  logic [1:0]    lane_sel;
  logic          busy;
  logic          img_done;
  logic          aborted;
  logic [4:0]    tiles_done;
  logic          err_spurious;

  tile_dispatch_scheduler #(
    .IMG_ROWS(32), .IMG_COLS(32), .BLOCK_SIZE(8), .NUM_LANES(NL)
  ) dut (
    .clk(clk), .rst(rst), .start_img(start_img), .abort(abort),
    .lane_done(lane_done), .lane_start(lane_start),
    .lane_tile_row(lane_tile_row), .lane_tile_col(lane_tile_col),
    .lane_sel(lane_sel), .busy(busy), .img_done(img_done), .aborted(aborted),
    .tiles_done(tiles_done), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int            m_phase;
  int            m_next;      // linear raster index of the next tile to hand out
  logic [NL-1:0] m_inflight;
  int            m_tiles;
  logic          m_err;
  logic          m_img;
  logic          m_abt;
  logic [NL-1:0] last_start;
  int            last_sel;
  int            n_img_seen;
  int            n_abt_seen;

  task automatic model_reset();
    m_phase = P_IDLE; m_next = 0; m_inflight = '0; m_tiles = 0;
    m_err = 1'b0; m_img = 1'b0; m_abt = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict and compare, then advance the model.
  task automatic run_cycle(input logic r, input logic s, input logic a, input logic [NL-1:0] d);
    logic [NL-1:0] e_start;
    logic [NL-1:0] acc;
    int e_sel;
    rst = r; start_img = s; abort = a; lane_done = d;
    e_start = '0;
    e_sel   = 0;
    if (m_phase == P_RUN && !a && m_inflight != {NL{1'b1}}) begin
      for (int k = NL - 1; k >= 0; k--) if (!m_inflight[k]) e_sel = k;
      e_start = NL'(1) << e_sel;
    end
    @(negedge clk);
    check("lane_start", lane_start, e_start);
    if (e_start != '0) begin
      check("lane_tile_row", lane_tile_row, m_next / NTC);
      check("lane_tile_col", lane_tile_col, m_next % NTC);
      check("lane_sel", lane_sel, e_sel);
    end
    check("busy", busy, m_phase != P_IDLE);
    check("img_done", img_done, m_img);
    check("aborted", aborted, m_abt);
    check("tiles_done", tiles_done, m_tiles);
    check("err_spurious", err_spurious, m_err);
    if (img_done === 1'b1) n_img_seen++;
    if (aborted === 1'b1) n_abt_seen++;
    last_start = e_start;
    last_sel   = e_sel;
    if (r) begin
      model_reset();
    end else begin
      acc = (m_phase != P_IDLE) ? (d & m_inflight) : '0;
      if ((d & ~acc) != '0) m_err = 1'b1;
      m_img = 1'b0;
      m_abt = 1'b0;
      case (m_phase)
        P_IDLE: if (s) begin
          m_phase = P_RUN; m_next = 0; m_tiles = 0; m_inflight = '0;
        end
        P_RUN: begin
          m_inflight = (m_inflight & ~acc) | e_start;
          m_tiles    = m_tiles + $countones(acc);
          if (a) m_phase = P_DRAIN;
          else if (e_start != '0) begin
            if (m_next == NT - 1) m_phase = P_DRAIN;
            else m_next++;
          end
        end
        default: begin
          if (m_inflight == '0 && d == '0) begin
            m_phase = P_IDLE;
            if (m_tiles == NT) m_img = 1'b1;
            else m_abt = 1'b1;
          end else begin
            m_inflight = m_inflight & ~acc;
            m_tiles    = m_tiles + $countones(acc);
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          start;
    logic          abort;
    logic [NL-1:0] done;
    logic [NL-1:0] e_start;
    int            e_row;
    int            e_col;
    int            e_sel;
    logic          e_busy;
    logic          e_img;
    logic          e_abt;
    int            e_tiles;
    logic          e_err;
  } vec_t;

  vec_t tv[22];
  int   timer[NL];

  initial begin
    //        rst st ab done     start  r c s  busy img abt tiles err
    tv[0]  = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0};  // reset state
    tv[1]  = '{0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0};  // start sampled
    tv[2]  = '{0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0, 1, 0, 0, 0, 0};  // first dispatch
    tv[3]  = '{0, 0, 0, 4'b0000, 4'b0010, 0, 1, 1, 1, 0, 0, 0, 0};
    tv[4]  = '{0, 0, 0, 4'b0001, 4'b0100, 0, 2, 2, 1, 0, 0, 0, 0};  // freed L0 not reused yet
    tv[5]  = '{0, 0, 0, 4'b0000, 4'b0001, 0, 3, 0, 1, 0, 0, 1, 0};
    tv[6]  = '{0, 0, 0, 4'b0110, 4'b1000, 1, 0, 3, 1, 0, 0, 1, 0};  // two done at once
    tv[7]  = '{0, 0, 0, 4'b0000, 4'b0010, 1, 1, 1, 1, 0, 0, 3, 0};  // lowest freed lane
    tv[8]  = '{0, 0, 0, 4'b0100, 4'b0100, 1, 2, 2, 1, 0, 0, 3, 0};  // done on idle lane 2
    tv[9]  = '{0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 3, 1};  // abort
    tv[10] = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 3, 1};  // drain
    tv[11] = '{0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 1, 0, 0, 3, 1};
    tv[12] = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 7, 1};
    tv[13] = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 7, 1};  // aborted pulse, busy low
    tv[14] = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 7, 1};
    tv[15] = '{0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 7, 1};  // abort ignored in idle
    tv[16] = '{0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0, 1, 0, 0, 0, 1};  // counters cleared, err kept
    tv[17] = '{0, 0, 0, 4'b0000, 4'b0010, 0, 1, 1, 1, 0, 0, 0, 1};
    tv[18] = '{0, 0, 0, 4'b0000, 4'b0100, 0, 2, 2, 1, 0, 0, 0, 1};
    tv[19] = '{1, 0, 0, 4'b0000, 4'b1000, 0, 3, 3, 1, 0, 0, 0, 1};  // rst with 3 lanes busy
    tv[20] = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0};  // everything back to reset
    tv[21] = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0};  // no late pulse

    rst = 1'b1; start_img = 1'b0; abort = 1'b0; lane_done = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      rst = tv[i].rst; start_img = tv[i].start; abort = tv[i].abort; lane_done = tv[i].done;
      @(negedge clk);
      check($sformatf("v%0d.lane_start", i), lane_start, tv[i].e_start);
      if (tv[i].e_start != '0) begin
        check($sformatf("v%0d.row", i), lane_tile_row, tv[i].e_row);
        check($sformatf("v%0d.col", i), lane_tile_col, tv[i].e_col);
        check($sformatf("v%0d.sel", i), lane_sel, tv[i].e_sel);
      end
      check($sformatf("v%0d.busy", i), busy, tv[i].e_busy);
      check($sformatf("v%0d.img_done", i), img_done, tv[i].e_img);
      check($sformatf("v%0d.aborted", i), aborted, tv[i].e_abt);
      check($sformatf("v%0d.tiles_done", i), tiles_done, tv[i].e_tiles);
      check($sformatf("v%0d.err", i), err_spurious, tv[i].e_err);
      @(posedge clk);
      #1;
    end

    // ---------------- randomized traffic against the model ----------------
    model_reset();
    n_img_seen = 0;
    n_abt_seen = 0;
    for (int k = 0; k < NL; k++) timer[k] = 0;
    run_cycle(1'b1, 1'b0, 1'b0, '0);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      logic [NL-1:0] d;
      logic s, a, r;
      int k2;
      d = '0;
      for (int k = 0; k < NL; k++) begin
        if (timer[k] == 1) d[k] = 1'b1;
        if (timer[k] != 0) timer[k]--;
      end
      if ($urandom_range(0, 99) == 0) begin
        k2 = $urandom_range(0, NL - 1);
        if (!m_inflight[k2]) d[k2] = 1'b1;
      end
      s = (m_phase == P_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      if (m_phase == P_RUN)
        a = (m_next == NT - 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      else
        a = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 1999) == 0);
      run_cycle(r, s, a, d);
      if (r) begin
        for (int k = 0; k < NL; k++) timer[k] = 0;
      end else if (last_start != '0) begin
        timer[last_sel] = $urandom_range(1, 6);
      end
    end

    // ---------------- abort coinciding with the final dispatch ----------------
    begin
      logic [NL-1:0] prev;
      int guard;
      run_cycle(1'b1, 1'b0, 1'b0, '0);
      n_img_seen = 0;
      n_abt_seen = 0;
      run_cycle(1'b0, 1'b1, 1'b0, '0);
      prev  = '0;
      guard = 0;
      while (!(m_phase == P_RUN && m_next == NT - 1) && guard < 40) begin
        run_cycle(1'b0, 1'b0, 1'b0, prev);
        prev = last_start;
        guard++;
      end
      check("final_tile_reached", guard < 40, 1);
      run_cycle(1'b0, 1'b0, 1'b1, prev);   // abort in the cycle tile 15 would go out
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, '0);
      check("abort_final.tiles_done", tiles_done, NT - 1);
      check("abort_final.aborted_pulses", n_abt_seen, 1);
      check("abort_final.img_done_pulses", n_img_seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
